fb_write_port: RTL

Frame-buffer write responder for the rasterizer's pixel interface. Accepts one pixel per `frame_rd_en`/`frame_ready` handshake and buffers it in a small FIFO. Each pixel is converted to a linear SRAM address in the current draw bank and written out through a req/gnt memory port. On `raster_done` it drains, waits for display vblank, then swaps the draw and display banks (double buffering).

---
 rtl/fb_write_port_if.sv | 34 +++
 rtl/fb_write_port.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fb_write_port_if.sv
// Pixel and memory-port bundles for fb_write_port.
// fb_pix_if: rasterizer -> frame buffer; fb_mem_if: frame buffer -> SRAM.
interface fb_pix_if;
  logic       frame_rd_en;
  logic [9:0] frame_x;
  logic [8:0] frame_y;
  logic [2:0] px_color;
  logic       frame_ready;

  modport master (
    output frame_rd_en, frame_x, frame_y, px_color,
    input  frame_ready
  );
  modport slave (
    input  frame_rd_en, frame_x, frame_y, px_color,
    output frame_ready
  );
endinterface

interface fb_mem_if;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_gnt;

  modport master (
    output mem_req, mem_addr, mem_wdata,
    input  mem_gnt
  );
  modport slave (
    input  mem_req, mem_addr, mem_wdata,
    output mem_gnt
  );
endinterface

// File: rtl/fb_write_port.sv
// Double-buffered frame-buffer write port: pixel FIFO -> linear SRAM writes.
// Ports: clk, rst (async, active-low), pix (slave), mem (master),
//   raster_done, disp_vblank in; disp_bank, swap_done, oob_count out.
//   Define FB_OOB_COUNT_EN to enable the out-of-range pixel counter.
module fb_write_port #(
  parameter int DEPTH = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst,
  fb_pix_if.slave     pix,
  fb_mem_if.master    mem,
  input  logic        raster_done,
  input  logic        disp_vblank,
  output logic        disp_bank,
  output logic        swap_done,
  output logic [15:0] oob_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ACCEPT,
    DRAIN,
    WAIT_VB
  } state_e;

  state_e      state_q, state_d;
  logic        bank_q, bank_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [19:0] addr_mem [DEPTH];
  logic [2:0]  col_mem  [DEPTH];

  logic        ready;
  logic        in_range;
  logic        push;
  logic        pop;
  logic [18:0] lin;

  assign in_range = (pix.frame_x < 10'(H_RES))
                  && (pix.frame_y < 9'(V_RES));

  assign lin = 19'(pix.frame_y) * 19'(H_RES)
             + 19'(pix.frame_x);

  assign push = pix.frame_rd_en & ready & in_range;
  assign pop  = mem.mem_req & mem.mem_gnt;

  assign pix.frame_ready = ready;
  assign disp_bank       = ~bank_q;

  // Outputs are gated to zero while empty so idle/reset reads 0.
  assign mem.mem_req   = (count_q != '0);
  assign mem.mem_addr  = mem.mem_req ? addr_mem[rd_q] : '0;
  assign mem.mem_wdata = mem.mem_req ? col_mem[rd_q]  : '0;

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    ready     = 1'b0;
    swap_done = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        ready = (count_q < (AW+1)'(DEPTH));
        if (raster_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_q == '0) state_d = WAIT_VB;
      end
      WAIT_VB: begin
        if (disp_vblank) begin
          swap_done = 1'b1;
          bank_d    = ~bank_q;
          state_d   = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCEPT;
      bank_q  <= 1'b0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      count_q <= count_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Bank bit is captured at enqueue so a pixel racing raster_done
  // still lands in the frame it was drawn for.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_q] <= {bank_q, lin};
      col_mem[wr_q]  <= pix.px_color;
    end
  end

`ifdef FB_OOB_COUNT_EN
  logic [15:0] oob_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oob_q <= '0;
    end else if (pix.frame_rd_en & ready & ~in_range
                 & ~&oob_q) begin
      oob_q <= oob_q + 16'd1;
    end
  end

  assign oob_count = oob_q;
`else
  assign oob_count = '0;
`endif

endmodule
